// File: rtl/note_sequencer_if.sv
// Control/table-write bus and PWM-facing outputs of the note sequencer.
// The master side drives requests and table writes; the slave is the sequencer.
interface note_sequencer_if #(
    parameter int AW = 4
);
    logic          start;
    logic          stop;
    logic          loop_en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [7:0]    freq_code;
    logic          busy;
    logic          done;
    logic [AW-1:0] step_addr;

    modport master (
        output start, stop, loop_en, wr_en, wr_addr, wr_data,
        input  freq_code, busy, done, step_addr
    );

    modport slave (
        input  start, stop, loop_en, wr_en, wr_addr, wr_data,
        output freq_code, busy, done, step_addr
    );
endinterface

// File: rtl/note_sequencer.sv
// Tempo-driven note sequencer: plays (code, duration) table entries into the
// PWM generator's frequency input, with a silent gap after every note.
module note_sequencer #(
    parameter int DEPTH     = 16,
    parameter int TICK_DIV  = 48000,
    parameter int GAP_TICKS = 1
) (
    input  logic            clk,
    input  logic            reset,
    note_sequencer_if.slave bus
);
    localparam int AW       = $clog2(DEPTH);
    localparam int PW       = $clog2(TICK_DIV);
    localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
    localparam int GW       = $clog2(GAP_LAST + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0]    freq_q, freq_d;
    logic [7:0]    dur_q, dur_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   seq_table [DEPTH];
    logic [15:0]   entry;
    logic          tick;
    logic          advance;
    logic          end_seq;

    // Writes land at any time; the FSM only samples an entry while in LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                seq_table[i] <= '0;
            end
        end else if (bus.wr_en) begin
            seq_table[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign entry = seq_table[idx_q];
    assign tick  = ((state_q == S_PLAY) || (state_q == S_GAP)) &&
                   (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        freq_d  = freq_q;
        dur_d   = dur_q;
        presc_d = '0;
        gap_d   = gap_q;
        advance = 1'b0;
        end_seq = 1'b0;

        case (state_q)
            S_IDLE: begin
                freq_d = '0;
                idx_d  = '0;
                if (bus.start && !bus.stop) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (entry[7:0] != 8'd0) begin
                    freq_d  = entry[15:8];
                    dur_d   = entry[7:0];
                    state_d = S_PLAY;
                end else begin
                    end_seq = 1'b1;
                end
            end
            S_PLAY: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    dur_d = dur_q - 8'd1;
                    if (dur_q == 8'd1) begin
                        if (GAP_TICKS > 0) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                            freq_d  = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (gap_q == GW'(GAP_LAST)) begin
                        advance = 1'b1;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            if (idx_q != AW'(DEPTH - 1)) begin
                idx_d   = idx_q + AW'(1);
                freq_d  = '0;
                state_d = S_LOAD;
            end else begin
                end_seq = 1'b1;
            end
        end

        // Looping from index 0 would spin forever on an empty table, so it finishes instead.
        if (end_seq) begin
            freq_d = '0;
            idx_d  = '0;
            if (bus.loop_en && (idx_q != '0)) begin
                state_d = S_LOAD;
            end else begin
                state_d = S_DONE;
            end
        end

        if (bus.stop && ((state_q == S_LOAD) || (state_q == S_PLAY) || (state_q == S_GAP))) begin
            state_d = S_IDLE;
            idx_d   = '0;
            freq_d  = '0;
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            freq_q  <= '0;
            dur_q   <= '0;
            presc_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            freq_q  <= freq_d;
            dur_q   <= dur_d;
            presc_q <= presc_d;
            gap_q   <= gap_d;
        end
    end

    assign bus.freq_code = freq_q;
    assign bus.busy      = (state_q == S_LOAD) || (state_q == S_PLAY) || (state_q == S_GAP);
    assign bus.done      = (state_q == S_DONE);
    assign bus.step_addr = idx_q;
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Tempo-driven note sequencer that plays a programmable table of (frequency code, duration) entries into the PWM audio generator's 8-bit frequency input. It sits between the control interface and the PWM audio datapath on `clk`. It steps through the table on tempo ticks, inserts a silent gap between notes, and optionally loops. Code 0x00 is silence at the generator.

## Interface
- `DEPTH`, 16: table entries; address width `AW` = clog2(`DEPTH`)
- `TICK_DIV`, 48000: `clk` cycles per tempo tick, ≥2
- `GAP_TICKS`, 1: silent ticks after each note, ≥0

- `clk`  input  1  single clock, all logic on rising edge
- `reset`  input  1  asynchronous active-low reset
- `start`  input  1  level-sampled request to begin playback from entry 0
- `stop`  input  1  abort playback
- `loop_en`  input  1  restart at entry 0 at end of table instead of finishing
- `wr_en`  input  1  table write strobe
- `wr_addr`  input  AW  table write address
- `wr_data`  input  16  [15:8] frequency code, [7:0] duration in ticks (0 = end marker)
- `freq_code`  output  8  registered code to the PWM generator
- `busy`  output  1  high in LOAD/PLAY/GAP
- `done`  output  1  one-cycle pulse on natural completion
- `step_addr`  output  AW  index of the entry being loaded/played

## Operation
- Table: `DEPTH` x 16 flops, cleared to 0 on reset. A write is accepted on any cycle. The FSM latches an entry only in LOAD, so rewriting the playing entry affects only its next fetch.
- Prescaler: counts 0..`TICK_DIV`-1 in PLAY and GAP only. It is cleared on every entry to PLAY or GAP. A tick occurs on the cycle it equals `TICK_DIV`-1.
- States: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE:
  - `freq_code`=0, `busy`=0, idx=0.
  - `start`=1 and `stop`=0 → LOAD.
- LOAD (1 cycle): read entry[idx].
  - duration ≠ 0 → latch code and duration into dur_cnt, go to PLAY.
  - duration = 0 → end-of-sequence.
- PLAY:
  - `freq_code` = latched code.
  - Each tick decrements dur_cnt.
  - Tick with dur_cnt=1 → GAP if `GAP_TICKS`>0, else advance.
- GAP:
  - `freq_code`=0.
  - After `GAP_TICKS` ticks → advance.
- Advance:
  - idx < `DEPTH`-1 → idx+1, LOAD.
  - idx = `DEPTH`-1 → end-of-sequence.
- End-of-sequence:
  - `loop_en`=1 and idx≠0 → idx=0, LOAD.
  - Otherwise → DONE. An empty table never loops.
- DONE (1 cycle): `done`=1, `freq_code`=0, `busy`=0, then IDLE.
- `stop`=1 in LOAD/PLAY/GAP → IDLE next cycle: `freq_code`=0, idx=0, no `done` pulse.
- `start` while busy is ignored. `start` and `stop` in the same cycle → stop wins.
- `loop_en` is sampled only at end-of-sequence.

## Timing
- Reset values: `freq_code`=0x00, `busy`=0, `done`=0, `step_addr`=0, FSM=IDLE, prescaler=0, dur_cnt=0, table all zero.
- Reset asserted mid-playback forces all of the above immediately (asynchronous). Release is synchronous to `clk`.
- `start` sampled at edge t:
  - LOAD during cycle t+1 (`busy`=1 from t+1).
  - `freq_code` valid from t+2.
- PLAY length is exactly duration x `TICK_DIV` cycles. GAP length is exactly `GAP_TICKS` x `TICK_DIV` cycles.
- Each note period is 1 + (duration + `GAP_TICKS`) x `TICK_DIV` cycles.
- `step_addr` updates on entry to LOAD and holds through PLAY/GAP.
- `freq_code` changes only on state entry, so it is glitch-free and registered.
- `done` is high exactly one cycle; `busy` falls in the same cycle.
- Duration 0xFF plays 255 ticks. dur_cnt is 8-bit, with no wrap.

## Test plan
- Reset/idle (`TICK_DIV`=4, `GAP_TICKS`=1 for all scenarios): assert `reset`=0 mid-PLAY → `freq_code`=0, `busy`=0, `step_addr`=0 without waiting for a clock edge. Release, then pulse `start` with an all-zero table → LOAD, DONE; `done` pulse at t+2; `freq_code` stays 0.
- Basic play:
  - Table is {0x40,2}, {0x80,1}, {0x00,0}; pulse `start` at t.
  - `freq_code`=0x40 for cycles t+2..t+9, then 0 for 4 cycles, LOAD, then 0x80 for 4 cycles.
  - Then 0 for 4 cycles, LOAD (terminator), `done` pulse, IDLE.
- Loop: same table with `loop_en`=1 → after entry 1's gap, `step_addr` returns to 0 and 0x40 replays. Clear `loop_en` → next terminator yields `done`.
- Full table wrap: all `DEPTH` entries have duration 1 and `loop_en`=0 → after entry `DEPTH`-1, DONE with no terminator read. `step_addr` visits 0..`DEPTH`-1 in order.
- Stop/start contention:
  - `stop` mid-PLAY → IDLE next cycle, `freq_code`=0, no `done`.
  - `start`+`stop` same cycle in IDLE → remains IDLE.
  - `start` while busy → no restart; `step_addr` unchanged.
- Live write: overwrite entry 0 with {0x22,1} while entry 0 plays → current note continues at 0x40 for its full length. On the next loop pass, 0x22 plays for 4 cycles.
